// File: rtl/fifo_prog_pkg.sv
// Shared types and constants for fifo_prog and wrappers around it.
package fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam logic RST_FULL         = 1'b0;
    localparam logic RST_EMPTY        = 1'b1;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
    localparam logic RST_OVERFLOW     = 1'b0;
    localparam logic RST_UNDERFLOW    = 1'b0;

endpackage

// File: rtl/fifo_prog_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
module fifo_prog_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable thresholds, flush and sticky errors.
// Define FIFO_PROG_FWFT_EN for first-word-fall-through reads.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             pre_full,
    output logic             pre_empty,
    input  logic [CNT_W-1:0] af_thresh,
    input  logic [CNT_W-1:0] ae_thresh,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] rd_addr;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en;
    logic             rd_en;
    logic             ovf_set;
    logic             udf_set;

    // Acceptance uses the registered full/empty, so a read at full never frees
    // a slot for the write in the same cycle.
    always_comb begin
        wr_en      = w_valid && !pre_full && !flush && !reset;
        rd_en      = r_ready && !pre_empty && !flush && !reset;
        ovf_set    = w_valid && pre_full && !flush;
        udf_set    = r_ready && pre_empty && !flush;
        rd_ptr_nxt = rd_en ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt  = count;
        if (reset || flush) begin
            count_nxt = '0;
        end else if (wr_en && !rd_en) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_nxt = count - CNT_W'(1);
        end
    end

`ifdef FIFO_PROG_FWFT_EN
    assign rd_addr = rd_ptr_nxt;
`else
    assign rd_addr = rd_ptr;
`endif

    fifo_prog_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr_nxt;
        end
        count <= count_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_full     <= RST_FULL;
            pre_empty    <= RST_EMPTY;
            almost_full  <= (af_thresh == '0);
            almost_empty <= RST_ALMOST_EMPTY;
        end else begin
            pre_full     <= (count_nxt == FULL_CNT);
            pre_empty    <= (count_nxt == '0);
            almost_full  <= (count_nxt >= af_thresh);
            almost_empty <= (count_nxt <= ae_thresh);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= RST_OVERFLOW;
            underflow <= RST_UNDERFLOW;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_PROG_FWFT_EN
    // The next head bypasses memory when it is the word being written now.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (count_nxt != '0) begin
            if (count == '0 || (count == CNT_W'(1) && rd_en)) begin
                data_out <= data_in;
            end else begin
                data_out <= rd_data;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Directed and scoreboard checks for fifo_prog (DEPTH=4, WIDTH=8), both read modes.
module tb_fifo_prog;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             w_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             r_ready = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             pre_full;
    logic             pre_empty;
    logic [CNT_W-1:0] af_thresh = 3'd4;
    logic [CNT_W-1:0] ae_thresh = 3'd0;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             clr_err = 1'b0;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    fifo_prog #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .w_valid      (w_valid),
        .data_in      (data_in),
        .r_ready      (r_ready),
        .data_out     (data_out),
        .pre_full     (pre_full),
        .pre_empty    (pre_empty),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [WIDTH-1:0] d);
        w_valid = 1'b1;
        data_in = d;
        step();
        w_valid = 1'b0;
    endtask

    // FWFT shows the head before the read edge; registered mode shows it after.
    task automatic read_expect(input string tag, input logic [WIDTH-1:0] exp);
`ifdef FIFO_PROG_FWFT_EN
        check(tag, data_out, exp);
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
`else
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
        check(tag, data_out, exp);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] mq[$];
        logic [WIDTH-1:0] exp_dout;
        logic [WIDTH-1:0] d;
        logic             w, r, wa, ra;

        // reset state
        step();
        step();
        reset = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", pre_empty, 1);
        check("rst_full", pre_full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_aempty", almost_empty, 1);
        check("rst_ovf", overflow, 0);
        check("rst_udf", underflow, 0);
        check("rst_dout", data_out, 0);

        // fill / drain
        write(8'hA0);
`ifdef FIFO_PROG_FWFT_EN
        check("fwft_first_word", data_out, 8'hA0);
`endif
        check("fill_empty_fall", pre_empty, 0);
        write(8'hA1);
        write(8'hA2);
        write(8'hA3);
        check("fill_full", pre_full, 1);
        check("fill_count", count, 4);
        read_expect("drain0", 8'hA0);
        read_expect("drain1", 8'hA1);
        read_expect("drain2", 8'hA2);
        read_expect("drain3", 8'hA3);
        check("drain_empty", pre_empty, 1);
        check("drain_count", count, 0);

        // overflow with simultaneous read
        for (int i = 0; i < 4; i++) write(8'h10 + 8'(i));
        w_valid = 1'b1; data_in = 8'hFF; r_ready = 1'b1;
        step();
        w_valid = 1'b0; r_ready = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 3);
        check("ovf_full", pre_full, 0);
`ifdef FIFO_PROG_FWFT_EN
        check("ovf_dout", data_out, 8'h11);
`else
        check("ovf_dout", data_out, 8'h10);
`endif
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("ovf_clr", overflow, 0);
        read_expect("ovf_drain1", 8'h11);
        read_expect("ovf_drain2", 8'h12);
        read_expect("ovf_drain3", 8'h13);
        check("ovf_drained", pre_empty, 1);

        // underflow with simultaneous write
        w_valid = 1'b1; data_in = 8'h55; r_ready = 1'b1;
        step();
        w_valid = 1'b0; r_ready = 1'b0;
        check("udf_flag", underflow, 1);
        check("udf_count", count, 1);
        read_expect("udf_read", 8'h55);
        check("udf_count0", count, 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("udf_clr", underflow, 0);

        // thresholds
        af_thresh = 3'd3; ae_thresh = 3'd1;
        step();
        check("thr_af0", almost_full, 0);
        check("thr_ae0", almost_empty, 1);
        write(8'h30);
        check("thr_ae1", almost_empty, 1);
        write(8'h31);
        check("thr_ae2", almost_empty, 0);
        check("thr_af2", almost_full, 0);
        write(8'h32);
        check("thr_af3", almost_full, 1);
        check("thr_cnt3", count, 3);
        read_expect("thr_rd0", 8'h30);
        check("thr_af_fall", almost_full, 0);
        read_expect("thr_rd1", 8'h31);
        read_expect("thr_rd2", 8'h32);

        // flush, out-of-range thresholds, reset with overflow set
        af_thresh = 3'd5; ae_thresh = 3'd4;
        write(8'h40);
        write(8'h41);
        flush = 1'b1; w_valid = 1'b1; data_in = 8'h42; r_ready = 1'b1;
        step();
        flush = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
        check("flush_count", count, 0);
        check("flush_empty", pre_empty, 1);
        check("flush_ovf", overflow, 0);
        check("flush_udf", underflow, 0);
        for (int i = 0; i < 4; i++) write(8'h50 + 8'(i));
        check("bnd_full", pre_full, 1);
        check("bnd_af_high_thr", almost_full, 0);
        check("bnd_ae_high_thr", almost_empty, 1);
        read_expect("flush_head", 8'h50);
        write(8'h54);
        write(8'h99);
        check("pre_rst_ovf", overflow, 1);
        reset = 1'b1; af_thresh = 3'd0;
        step();
        reset = 1'b0;
        check("rst2_ovf", overflow, 0);
        check("rst2_count", count, 0);
        check("rst2_dout", data_out, 0);
        check("rst2_af_zero_thr", almost_full, 1);
        check("rst2_empty", pre_empty, 1);

        // random concurrent traffic against a scoreboard
        af_thresh = 3'd4; ae_thresh = 3'd0;
        step();
        exp_dout = '0;
        for (int i = 0; i < 1000; i++) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            w_valid = w; r_ready = r; data_in = d;
            wa = w && (mq.size() < DEPTH);
            ra = r && (mq.size() > 0);
            step();
            if (ra) begin
`ifdef FIFO_PROG_FWFT_EN
                void'(mq.pop_front());
`else
                exp_dout = mq.pop_front();
`endif
            end
            if (wa) mq.push_back(d);
`ifdef FIFO_PROG_FWFT_EN
            if (mq.size() > 0) exp_dout = mq[0];
`endif
            check("rnd_count", count, mq.size());
            check("rnd_dout", data_out, exp_dout);
            check("rnd_full", pre_full, mq.size() == DEPTH);
            check("rnd_empty", pre_empty, mq.size() == 0);
        end
        w_valid = 1'b0; r_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
